// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: per-stage write-enables/flushes, memory-wait
// watchdog, halt/resume handling and a saturating stall counter.
module pipeline_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  ex_is_jump,
  input  logic                  mem_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  input  logic                  wb_halt,
  input  logic                  resume,
  output logic                  pc_we,
  output logic                  if_id_we,
  output logic                  id_ex_we,
  output logic                  ex_mem_we,
  output logic                  mem_wb_we,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush,
  output logic [1:0]            state,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic load_use;
  logic mem_stall;
  logic advance;

  assign load_use  = ex_mem_read &&
                     ((id_uses_rs && (id_rs == ex_dst)) ||
                      (id_uses_rt && (id_rt == ex_dst)));
  assign mem_stall = mem_req && !mem_ack;

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = mem_err_q;
    advance      = 1'b0;

    case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = 16'd1;
        end else begin
          advance = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          advance = 1'b1;
          state_d = S_RUN;
        end else if (wait_cnt_q == 16'(MEM_TIMEOUT)) begin
          state_d   = S_ERROR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      S_HALT: begin
        if (resume) state_d = S_RUN;
      end
      default: ;
    endcase

    // Frozen pipe: the instruction in MEM is held, a bubble drains into WB.
    if (!advance && (state_q == S_RUN || state_q == S_MEM_WAIT)) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
      mem_wb_flush = 1'b1;
    end else if (!advance) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
    end

    if (advance) begin
      if (mem_branch_taken) begin
        {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
      end else if (ex_is_jump) begin
        {if_id_flush, id_ex_flush} = 2'b11;
      end else if (load_use) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end
      // Halt lets only the retiring instruction through; redirect flushes still land.
      if (wb_halt) begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00001;
        state_d = S_HALT;
      end
    end

    if (rst) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b0000;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (state_q != S_ERROR && !pc_we && stall_q != {CNT_W{1'b1}})
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= 16'd0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      stall_q    <= stall_d;
    end
  end

  assign state       = state_q;
  assign mem_err     = mem_err_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a rule-level model.
module tb_pipeline_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] id_rs, id_rt, ex_dst;
  logic id_uses_rs, id_uses_rt, ex_mem_read, ex_is_jump, mem_branch_taken;
  logic mem_req, mem_ack, wb_halt, resume;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0] state;
  logic mem_err;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REG_ADDR_W(4), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .ex_is_jump(ex_is_jump),
    .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .wb_halt(wb_halt), .resume(resume),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .state(state), .mem_err(mem_err), .stall_count(stall_count)
  );

  // {pc, if_id, id_ex, ex_mem, mem_wb} write-enables, then the four flushes.
  logic [8:0] outs;
  assign outs = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  typedef struct packed {
    logic [3:0] rs, rt;
    logic       urs, urt, rd;
    logic [3:0] dst;
    logic       jmp, br, req, ack, halt, res;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [8:0] exp_out;
    logic [1:0] exp_state;
    logic [3:0] exp_cnt;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mkin(int rs, int rt, bit urs, bit urt, bit rd, int dst,
                               bit jmp, bit br, bit req, bit ack, bit halt, bit res);
    in_t v;
    v.rs = 4'(rs); v.rt = 4'(rt); v.urs = urs; v.urt = urt; v.rd = rd; v.dst = 4'(dst);
    v.jmp = jmp; v.br = br; v.req = req; v.ack = ack; v.halt = halt; v.res = res;
    return v;
  endfunction

  task automatic drive(input in_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_mem_read = v.rd; ex_dst = v.dst; ex_is_jump = v.jmp; mem_branch_taken = v.br;
    mem_req = v.req; mem_ack = v.ack; wb_halt = v.halt; resume = v.res;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive('0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: expected stage controls from the rules, given mode 0..3.
  function automatic logic [8:0] model_outs(int mode, in_t v);
    logic [4:0] we;
    logic [3:0] fl;
    bit load_use;
    if (mode >= 2) return 9'b0;
    if ((mode == 0 && v.req && !v.ack) || (mode == 1 && !v.ack)) return 9'b00000_0001;
    load_use = v.rd && ((v.urs && v.rs == v.dst) || (v.urt && v.rt == v.dst));
    we = 5'b11111;
    fl = 4'b0000;
    if (v.br)           fl = 4'b1110;
    else if (v.jmp)     fl = 4'b1100;
    else if (load_use) begin fl = 4'b0100; we = 5'b00111; end
    if (v.halt) we = 5'b00001;
    return {we, fl};
  endfunction

  vec_t tbl[15];
  int m_state, m_cnt, m_stall;
  bit m_err;

  initial begin
    drive('0);
    // in, outs, next state, stall_count after one edge from reset
    tbl[0]  = '{mkin(5,0,1,0,1,5,0,0,0,0,0,0), 9'b00111_0100, 2'd0, 4'd1};
    tbl[1]  = '{mkin(5,0,0,0,1,5,0,0,0,0,0,0), 9'b11111_0000, 2'd0, 4'd0};
    tbl[2]  = '{mkin(3,7,1,1,1,7,0,0,0,0,0,0), 9'b00111_0100, 2'd0, 4'd1};
    tbl[3]  = '{mkin(0,2,1,0,1,0,0,0,0,0,0,0), 9'b00111_0100, 2'd0, 4'd1};
    tbl[4]  = '{mkin(5,5,1,1,0,5,0,0,0,0,0,0), 9'b11111_0000, 2'd0, 4'd0};
    tbl[5]  = '{mkin(5,0,1,0,1,5,0,1,0,0,0,0), 9'b11111_1110, 2'd0, 4'd0};
    tbl[6]  = '{mkin(0,0,0,0,0,0,1,0,0,0,0,0), 9'b11111_1100, 2'd0, 4'd0};
    tbl[7]  = '{mkin(0,0,0,0,0,0,1,1,0,0,0,0), 9'b11111_1110, 2'd0, 4'd0};
    tbl[8]  = '{mkin(0,0,0,0,0,0,0,1,1,0,0,0), 9'b00000_0001, 2'd1, 4'd1};
    tbl[9]  = '{mkin(0,0,0,0,0,0,1,0,1,1,0,0), 9'b11111_1100, 2'd0, 4'd0};
    tbl[10] = '{mkin(0,0,0,0,0,0,0,0,0,0,1,0), 9'b00001_0000, 2'd2, 4'd1};
    tbl[11] = '{mkin(0,0,0,0,0,0,0,1,0,0,1,0), 9'b00001_1110, 2'd2, 4'd1};
    tbl[12] = '{mkin(0,0,0,0,0,0,0,0,1,0,1,0), 9'b00000_0001, 2'd1, 4'd1};
    tbl[13] = '{mkin(0,0,0,0,0,0,0,0,0,0,0,1), 9'b11111_0000, 2'd0, 4'd0};
    tbl[14] = '{mkin(9,0,1,0,1,9,0,0,0,0,1,0), 9'b00001_0100, 2'd2, 4'd1};

    rst = 1'b1;
    #1;
    check("reset_outs", 32'(outs), 32'h1F0);
    check("reset_state", 32'(state), 0);
    check("reset_stall", 32'(stall_count), 0);
    check("reset_err", 32'(mem_err), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      do_reset();
      drive(tbl[i].in);
      #1;
      $display("vec %0d: outs=%09b state=%0d", i, outs, state);
      check($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].exp_out));
      tick();
      check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
      check($sformatf("vec%0d_stall", i), 32'(stall_count), 32'(tbl[i].exp_cnt));
    end

    // Memory wait: three stalled cycles, then ack with a pending branch.
    do_reset();
    drive(mkin(0,0,0,0,0,0,0,1,1,0,0,0));
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mw_outs", 32'(outs), 32'h001);
      tick();
      check("mw_state", 32'(state), 1);
      @(negedge clk);
    end
    drive(mkin(0,0,0,0,0,0,0,1,1,1,0,0));
    #1;
    check("mw_ack_outs", 32'(outs), 32'h1FE);
    tick();
    check("mw_ack_state", 32'(state), 0);
    check("mw_stall", 32'(stall_count), 3);
    $display("memwait done: state=%0d stall=%0d", state, stall_count);

    // Timeout: ERROR after the 5th stalled edge; ack/resume ignored; rst clears.
    do_reset();
    drive(mkin(0,0,0,0,0,0,0,0,1,0,0,0));
    for (int k = 1; k <= TMO + 1; k++) begin
      tick();
      check($sformatf("tmo_state%0d", k), 32'(state), (k <= TMO) ? 1 : 3);
    end
    check("tmo_err", 32'(mem_err), 1);
    @(negedge clk);
    drive(mkin(0,0,0,0,0,0,0,0,1,1,0,1));
    #1;
    check("err_outs", 32'(outs), 0);
    tick();
    check("err_state", 32'(state), 3);
    check("err_stall", 32'(stall_count), TMO + 1);
    do_reset();
    check("err_rst_state", 32'(state), 0);
    check("err_rst_err", 32'(mem_err), 0);
    $display("timeout done: state=%0d err=%0d", state, mem_err);

    // Halt and resume.
    do_reset();
    drive(mkin(0,0,0,0,0,0,0,0,0,0,1,0));
    #1;
    check("halt_outs", 32'(outs), 32'h010);
    tick();
    @(negedge clk);
    drive('0);
    #1;
    check("halted_state", 32'(state), 2);
    check("halted_outs", 32'(outs), 0);
    tick();
    @(negedge clk);
    drive(mkin(0,0,0,0,0,0,0,0,0,0,0,1));
    #1;
    check("resume_outs", 32'(outs), 0);
    tick();
    @(negedge clk);
    drive('0);
    #1;
    check("resume_state", 32'(state), 0);
    check("resume_outs_run", 32'(outs), 32'h1F0);
    $display("halt/resume done: stall=%0d", stall_count);

    // Stall counter saturates rather than wrapping.
    do_reset();
    drive(mkin(0,0,0,0,0,0,0,0,0,0,1,0));
    for (int k = 0; k < SAT + 5; k++) tick();
    check("stall_sat", 32'(stall_count), SAT);

    // Async reset between edges in MEM_WAIT.
    do_reset();
    drive(mkin(0,0,0,0,0,0,0,0,1,0,0,0));
    tick(); tick();
    @(negedge clk);
    check("ar_pre_state", 32'(state), 1);
    rst = 1'b1;
    #1;
    check("ar_state", 32'(state), 0);
    check("ar_err", 32'(mem_err), 0);
    check("ar_stall", 32'(stall_count), 0);
    check("ar_outs", 32'(outs), 32'h1F0);
    drive('0);
    @(negedge clk);
    rst = 1'b0;
    $display("async reset done");

    // Randomized run against the rule-level model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_t v;
      logic [8:0] exp_o;
      if (cyc % 60 == 0) begin
        do_reset();
        m_state = 0; m_cnt = 0; m_err = 0; m_stall = 0;
      end else begin
        @(negedge clk);
      end
      v.rs = 4'($urandom_range(0, 3)); v.rt = 4'($urandom_range(0, 3));
      v.dst = 4'($urandom_range(0, 3));
      v.urs = 1'($urandom_range(0, 1)); v.urt = 1'($urandom_range(0, 1));
      v.rd = 1'($urandom_range(0, 1));
      v.jmp = ($urandom_range(0, 5) == 0); v.br = ($urandom_range(0, 5) == 0);
      v.req = ($urandom_range(0, 3) == 0); v.ack = ($urandom_range(0, 2) == 0);
      v.halt = ($urandom_range(0, 15) == 0); v.res = ($urandom_range(0, 3) == 0);
      drive(v);
      #1;
      exp_o = model_outs(m_state, v);
      $display("rnd %0d: st=%0d outs=%09b exp=%09b", cyc, state, outs, exp_o);
      check("rnd_outs", 32'(outs), 32'(exp_o));
      if (m_state != 3 && !exp_o[8] && m_stall < SAT) m_stall++;
      case (m_state)
        0: if (v.req && !v.ack) begin m_state = 1; m_cnt = 1; end
           else if (v.halt) m_state = 2;
        1: if (v.ack) m_state = v.halt ? 2 : 0;
           else if (m_cnt == TMO) begin m_state = 3; m_err = 1; end
           else m_cnt++;
        2: if (v.res) m_state = 0;
        default: ;
      endcase
      tick();
      check("rnd_state", 32'(state), m_state);
      check("rnd_stall", 32'(stall_count), m_stall);
      check("rnd_err", 32'(mem_err), 32'(m_err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
